alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one parameter: W, default 32, the data path width for operands and results.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the request this cycle.
REQ-006 The block SHALL have port in_funct, input, 6 bits: R-type funct field to decode.
REQ-007 The block SHALL have ports in_a and in_b, input, W bits each: the operands.
REQ-008 The block SHALL have ports alu_a and alu_b, output, W bits each: operands driven to the ALU stage.
REQ-009 The block SHALL have port alu_op, output, 3 bits: operation code driven to the ALU stage.
REQ-010 The block SHALL have port alu_out, input, W bits: ALU result, combinational from alu_a/alu_b/alu_op.
REQ-011 The block SHALL have port alu_zero, input, 1 bit: ALU flag, captured unchanged.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-014 The block SHALL have ports out_res (W bits) and out_flag (1 bit), outputs: captured alu_out and alu_zero.
REQ-015 The block SHALL have port out_err, output, 1 bit: the request carried an unsupported funct.
REQ-016 The block SHALL have port op_count, output, 16 bits: count of completed output handshakes.

Function
REQ-017 The funct decode SHALL be: 0x20/0x21 -> 1 (add); 0x22/0x23 -> 2 (sub); 0x24 -> 3 (and); 0x25 -> 4 (or); 0x26 -> 5 (xor); 0x27 -> 6 (nor).
REQ-018 Any other funct SHALL decode to alu_op 0 with the error bit set.
REQ-019 The FSM SHALL have exactly three states: IDLE, ISSUE and DONE.
REQ-020 In IDLE: in_ready=1, out_valid=0; on in_valid, latch in_a, in_b, the decoded op and the error bit, then go to ISSUE.
REQ-021 In ISSUE: drive alu_a, alu_b and alu_op from the latches; in_ready=0, out_valid=0; at the edge, capture alu_out into out_res, alu_zero into out_flag and the error latch into out_err, then go to DONE unconditionally.
REQ-022 In DONE: out_valid=1 and in_ready=out_ready; out_res, out_flag and out_err SHALL hold stable until the handshake completes.
REQ-023 In DONE, on out_ready with in_valid: complete the handshake, latch the new request and go to ISSUE (back-to-back operation, one result every 2 cycles).
REQ-024 In DONE, on out_ready without in_valid: go to IDLE.
REQ-025 In DONE, without out_ready: stay in DONE, holding the result and ignoring in_valid.
REQ-026 Latency SHALL be 2 edges: a request accepted at edge k gives out_valid=1 after edge k+1 and holds until the handshake.
REQ-027 Outside ISSUE, alu_a, alu_b and alu_op SHALL be 0.
REQ-028 op_count SHALL increment on each out_valid&&out_ready edge and wrap from 0xFFFF to 0x0000.
REQ-029 An erroring request SHALL complete normally, with out_err=1 and out_res equal to the captured alu_out (0 for op 0).
REQ-030 All outputs SHALL be registered or decoded only from state and latches; there SHALL be no combinational path from alu_out to out_res.

Reset
REQ-031 When rst_n=0, the block SHALL immediately enter IDLE and clear the latches, out_res, out_flag, out_err and op_count to 0.
REQ-032 During reset, in_ready SHALL be 1, out_valid 0, and alu_a/alu_b/alu_op 0.
REQ-033 Reset asserted in ISSUE or DONE SHALL abandon the operation; no handshake completes and op_count is not incremented.
REQ-034 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-035 in_funct=0x20, a=5, b=7, out_ready=1 -> alu_op=1 in ISSUE; out_res=12, out_err=0, out_valid after 2 edges; op_count=1.
REQ-036 in_funct=0x22, a=3, b=10, out_ready=0 for 4 cycles -> out_res=0xFFFFFFF9 held stable with out_valid=1 and in_ready=0; releasing out_ready gives one handshake.
REQ-037 Back-to-back: 0x24 then 0x27 with a=0xF0F0, b=0x0FF0, in_valid and out_ready held high -> results 0x00F0 then 0xFFFF000F on consecutive 2-cycle slots.
REQ-038 in_funct=0x00 -> alu_op=0, out_err=1, out_res=0, handshake completes.
REQ-039 rst_n pulled low during ISSUE -> immediate IDLE, out_valid=0, op_count unchanged at its reset value 0.
REQ-040 Preload op_count to 0xFFFF through 65535 operations -> the next handshake gives 0x0000.

Source files
------------

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - R-type funct decode and three-state issue FSM feeding an external combinational ALU
module alu_issue #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [5:0]   in_funct,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic         out_flag,
  output logic         out_err,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic         err_q;
  logic [2:0]   dec_op;
  logic         dec_err;
  logic         accept;
  logic         fire;

  always_comb begin
    dec_op  = 3'd0;
    dec_err = 1'b0;
    case (in_funct)
      6'h20, 6'h21: dec_op = 3'd1;
      6'h22, 6'h23: dec_op = 3'd2;
      6'h24:        dec_op = 3'd3;
      6'h25:        dec_op = 3'd4;
      6'h26:        dec_op = 3'd5;
      6'h27:        dec_op = 3'd6;
      default:      dec_err = 1'b1;
    endcase
  end

  // ALU operands are only presented while ISSUE, zero otherwise
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = 3'd0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = op_q;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'd0;
      err_q    <= 1'b0;
      out_res  <= '0;
      out_flag <= 1'b0;
      out_err  <= 1'b0;
      op_count <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= in_a;
        b_q   <= in_b;
        op_q  <= dec_op;
        err_q <= dec_err;
      end
      if (state == ISSUE) begin
        out_res  <= alu_out;
        out_flag <= alu_zero;
        out_err  <= err_q;
      end
      if (fire) op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed bench for alu_issue with a behavioural ALU attached
module tb_alu_issue;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [5:0]   in_funct;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic         out_flag;
  logic         out_err;
  logic [15:0]  op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'd1:    alu_out = alu_a + alu_b;
      3'd2:    alu_out = alu_a - alu_b;
      3'd3:    alu_out = alu_a & alu_b;
      3'd4:    alu_out = alu_a | alu_b;
      3'd5:    alu_out = alu_a ^ alu_b;
      3'd6:    alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  alu_issue #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_flag(out_flag), .out_err(out_err),
    .op_count(op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_funct = 6'h00;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_op_count", op_count, 0);
    check("rst_out_res", out_res, 0);
    tick(); tick();
    rst_n = 1'b1;

    // add 5+7, immediate consumer
    in_valid = 1'b1; in_funct = 6'h20; in_a = 5; in_b = 7; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("add_issue_op", alu_op, 1);
    check("add_issue_a", alu_a, 5);
    check("add_issue_in_ready", in_ready, 0);
    check("add_issue_out_valid", out_valid, 0);
    tick();
    check("add_out_valid", out_valid, 1);
    check("add_out_res", out_res, 12);
    check("add_out_err", out_err, 0);
    check("add_out_flag", out_flag, 0);
    check("add_done_in_ready", in_ready, 1);
    tick();
    check("add_op_count", op_count, 1);
    check("add_idle_out_valid", out_valid, 0);
    check("add_idle_alu_op", alu_op, 0);

    // sub 3-10 with stalled consumer; new requests ignored while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_funct = 6'h22; in_a = 3; in_b = 10;
    tick();
    in_valid = 1'b0;
    check("sub_issue_op", alu_op, 2);
    tick();
    in_valid = 1'b1; in_funct = 6'h25; in_a = 32'h1111; in_b = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      check("sub_hold_res", out_res, 32'hFFFF_FFF9);
      check("sub_hold_valid", out_valid, 1);
      check("sub_hold_in_ready", in_ready, 0);
      tick();
    end
    check("sub_hold_count", op_count, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("sub_release_in_ready", in_ready, 1);
    tick();
    check("sub_op_count", op_count, 2);
    check("sub_idle_out_valid", out_valid, 0);

    // back-to-back and / nor
    in_valid = 1'b1; in_funct = 6'h24; in_a = 32'hF0F0; in_b = 32'h0FF0; out_ready = 1'b1;
    tick();
    in_funct = 6'h27;
    tick();
    check("b2b_and_res", out_res, 32'h0000_00F0);
    check("b2b_and_valid", out_valid, 1);
    tick();
    check("b2b_count_a", op_count, 3);
    check("b2b_nor_issue_op", alu_op, 6);
    check("b2b_nor_issue_valid", out_valid, 0);
    in_valid = 1'b0;
    tick();
    check("b2b_nor_res", out_res, 32'hFFFF_000F);
    check("b2b_nor_valid", out_valid, 1);
    tick();
    check("b2b_count_b", op_count, 4);

    // unsupported funct
    in_valid = 1'b1; in_funct = 6'h00; in_a = 9; in_b = 4;
    tick();
    in_valid = 1'b0;
    check("err_issue_op", alu_op, 0);
    tick();
    check("err_out_err", out_err, 1);
    check("err_out_res", out_res, 0);
    check("err_out_flag", out_flag, 1);
    check("err_out_valid", out_valid, 1);
    tick();
    check("err_op_count", op_count, 5);

    // xor sets zero flag false, then error clears on good request
    in_valid = 1'b1; in_funct = 6'h26; in_a = 32'hFF; in_b = 32'h0F;
    tick();
    in_valid = 1'b0;
    tick();
    check("xor_out_res", out_res, 32'hF0);
    check("xor_out_err", out_err, 0);
    tick();
    check("xor_op_count", op_count, 6);

    // reset during ISSUE
    in_valid = 1'b1; in_funct = 6'h21; in_a = 1; in_b = 1;
    tick();
    in_valid = 1'b0;
    check("rst_mid_issue_op", alu_op, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_alu_op", alu_op, 0);
    check("rst_mid_op_count", op_count, 0);
    tick();
    check("rst_mid_held_valid", out_valid, 0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_funct = 6'h23; in_a = 20; in_b = 8;
    tick();
    in_valid = 1'b0;
    check("post_rst_accept_op", alu_op, 2);
    tick();
    check("post_rst_res", out_res, 12);
    tick();
    check("post_rst_op_count", op_count, 1);

    // counter wrap from preloaded 0xFFFF
    force dut.op_count = 16'hFFFF;
    #1;
    release dut.op_count;
    in_valid = 1'b1; in_funct = 6'h20; in_a = 2; in_b = 3;
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap_res", out_res, 5);
    tick();
    check("wrap_op_count", op_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
